// File: rtl/alu_pipe_if.sv
// Issue/memory-stage handshake bundle for alu_pipe: micro-op in, result/flags/branch out.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op;
    logic [3:0]           cond;
    logic [WIDTH-1:0]     oprd1;
    logic [WIDTH-1:0]     oprd2;
    logic [63:0]          next_rip;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   result;
    logic [63:0]          rflags;
    logic                 branch;
    logic [63:0]          branch_rip;

    modport master (
        output in_valid, op, cond, oprd1, oprd2, next_rip, out_ready,
        input  in_ready, out_valid, result, rflags, branch, branch_rip
    );

    modport slave (
        input  in_valid, op, cond, oprd1, oprd2, next_rip, out_ready,
        output in_ready, out_valid, result, rflags, branch, branch_rip
    );
endinterface

// File: rtl/alu_pipe.sv
// Execute-stage ALU with one-entry output register and iterative shift-add MUL.
// Define ALU_MUL_FAST_EN for a single-cycle combinational multiplier instead.
module alu_pipe #(
    parameter int unsigned WIDTH = 64
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush,
    alu_pipe_if.slave bus
);
    localparam int unsigned SHAMT_W = $clog2(WIDTH);
    localparam int unsigned RES_W   = 2 * WIDTH;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_MOV = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SAR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_JCC = 4'd10;
    localparam logic [3:0] OP_JMP = 4'd11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Architectural flags word: bit1 is the always-one reserved bit.
    function automatic logic [63:0] f_flags(input logic cf, input logic of,
                                            input logic [WIDTH-1:0] res);
        logic [63:0] f;
        f     = 64'h2;
        f[0]  = cf;
        f[2]  = ~^res[7:0];
        f[6]  = (res == '0);
        f[7]  = res[WIDTH-1];
        f[11] = of;
        return f;
    endfunction

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic             r_out_valid;
    logic [RES_W-1:0] r_result;
    logic [63:0]      r_rflags;
    logic             r_branch;
    logic [63:0]      r_branch_rip;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_accept;
    logic             w_is_mul_iter;
    logic             w_load_now;
    logic             w_mul_last;
    logic             w_mul_done;
    logic [RES_W-1:0] w_mul_prod;
    logic [63:0]      w_mul_flags;
    logic [63:0]      w_mul_rip;

    assign w_a = bus.oprd1;
    assign w_b = bus.oprd2;

    assign bus.in_ready   = !reset && (r_state == ST_IDLE) && (!r_out_valid || bus.out_ready) && !flush;
    assign bus.out_valid  = r_out_valid;
    assign bus.result     = r_result;
    assign bus.rflags     = r_rflags;
    assign bus.branch     = r_branch;
    assign bus.branch_rip = r_branch_rip;

    assign w_accept = bus.in_valid && bus.in_ready;

`ifdef ALU_MUL_FAST_EN
    localparam bit MUL_ITER = 1'b0;

    assign w_mul_prod = RES_W'(w_a) * RES_W'(w_b);
    assign w_mul_last = 1'b0;
    assign w_mul_rip  = bus.next_rip;
`else
    localparam bit MUL_ITER = 1'b1;

    logic [RES_W-1:0]   r_mcand;
    logic [RES_W-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHAMT_W-1:0] r_cnt;
    logic [63:0]        r_mul_rip;
    logic [RES_W-1:0]   w_acc_nxt;

    assign w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_last = (r_cnt == SHAMT_W'(WIDTH - 1));
    assign w_mul_prod = w_acc_nxt;
    assign w_mul_rip  = r_mul_rip;

    // Shift-add datapath: operands captured at accept, one multiplier bit per BUSY cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_mul_rip <= '0;
        end else if (w_accept && (bus.op == OP_MUL)) begin
            r_mcand   <= RES_W'(w_a);
            r_acc     <= '0;
            r_mplier  <= w_b;
            r_cnt     <= '0;
            r_mul_rip <= bus.next_rip;
        end else if (r_state == ST_BUSY) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + SHAMT_W'(1);
        end
    end
`endif

    assign w_mul_flags   = f_flags(|w_mul_prod[RES_W-1:WIDTH], |w_mul_prod[RES_W-1:WIDTH],
                                   w_mul_prod[WIDTH-1:0]);
    assign w_is_mul_iter = MUL_ITER && (bus.op == OP_MUL);
    assign w_load_now    = w_accept && !w_is_mul_iter;
    assign w_mul_done    = (r_state == ST_BUSY) && w_mul_last && !flush;

    // Arithmetic, shift and branch-target helpers.
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic               w_add_of;
    logic               w_sub_of;
    logic [SHAMT_W-1:0] w_shamt;
    logic [SHAMT_W-1:0] w_shl_idx;
    logic [SHAMT_W-1:0] w_shr_idx;
    logic [WIDTH-1:0]   w_shl;
    logic [WIDTH-1:0]   w_shr;
    logic [WIDTH-1:0]   w_sar;
    logic [63:0]        w_target;

    assign w_add     = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub     = {1'b0, w_a} - {1'b0, w_b};
    assign w_add_of  = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_add[WIDTH-1] != w_a[WIDTH-1]);
    assign w_sub_of  = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_sub[WIDTH-1] != w_a[WIDTH-1]);
    assign w_shamt   = w_b[SHAMT_W-1:0];
    // Last bit out of a left shift by n is bit WIDTH-n, i.e. -n modulo WIDTH.
    assign w_shl_idx = ~w_shamt + SHAMT_W'(1);
    assign w_shr_idx = w_shamt - SHAMT_W'(1);
    assign w_shl     = w_a << w_shamt;
    assign w_shr     = w_a >> w_shamt;
    assign w_sar     = $unsigned($signed(w_a) >>> w_shamt);
    assign w_target  = bus.next_rip + 64'($signed(w_b));

    // x86 condition evaluation against the last committed flags.
    logic w_cc_base;
    logic w_cc_true;
    always_comb begin
        w_cc_base = 1'b0;
        case (bus.cond[3:1])
            3'd0:    w_cc_base = r_rflags[11];
            3'd1:    w_cc_base = r_rflags[0];
            3'd2:    w_cc_base = r_rflags[6];
            3'd3:    w_cc_base = r_rflags[0] | r_rflags[6];
            3'd4:    w_cc_base = r_rflags[7];
            3'd5:    w_cc_base = r_rflags[2];
            3'd6:    w_cc_base = r_rflags[7] ^ r_rflags[11];
            default: w_cc_base = r_rflags[6] | (r_rflags[7] ^ r_rflags[11]);
        endcase
        w_cc_true = w_cc_base ^ bus.cond[0];
    end

    // Payload for a single-cycle load of the presented op.
    logic [RES_W-1:0] w_res;
    logic [63:0]      w_flags;
    logic             w_branch;
    logic [63:0]      w_brip;
    always_comb begin
        w_res    = RES_W'(w_b);
        w_flags  = r_rflags;
        w_branch = 1'b0;
        w_brip   = bus.next_rip;
        case (bus.op)
            OP_ADD: begin
                w_res   = RES_W'(w_add[WIDTH-1:0]);
                w_flags = f_flags(w_add[WIDTH], w_add_of, w_add[WIDTH-1:0]);
            end
            OP_SUB: begin
                w_res   = RES_W'(w_sub[WIDTH-1:0]);
                w_flags = f_flags(w_sub[WIDTH], w_sub_of, w_sub[WIDTH-1:0]);
            end
            OP_AND: begin
                w_res   = RES_W'(w_a & w_b);
                w_flags = f_flags(1'b0, 1'b0, w_a & w_b);
            end
            OP_OR: begin
                w_res   = RES_W'(w_a | w_b);
                w_flags = f_flags(1'b0, 1'b0, w_a | w_b);
            end
            OP_XOR: begin
                w_res   = RES_W'(w_a ^ w_b);
                w_flags = f_flags(1'b0, 1'b0, w_a ^ w_b);
            end
            OP_MOV: w_res = RES_W'(w_b);
            OP_SHL: begin
                w_res = RES_W'(w_a);
                if (w_shamt != '0) begin
                    w_res   = RES_W'(w_shl);
                    w_flags = f_flags(w_a[w_shl_idx], 1'b0, w_shl);
                end
            end
            OP_SHR: begin
                w_res = RES_W'(w_a);
                if (w_shamt != '0) begin
                    w_res   = RES_W'(w_shr);
                    w_flags = f_flags(w_a[w_shr_idx], 1'b0, w_shr);
                end
            end
            OP_SAR: begin
                w_res = RES_W'(w_a);
                if (w_shamt != '0) begin
                    w_res   = RES_W'(w_sar);
                    w_flags = f_flags(w_a[w_shr_idx], 1'b0, w_sar);
                end
            end
            OP_MUL: begin
                w_res   = w_mul_prod;
                w_flags = w_mul_flags;
            end
            OP_JCC: begin
                w_res    = '0;
                w_branch = w_cc_true;
                w_brip   = w_cc_true ? w_target : bus.next_rip;
            end
            OP_JMP: begin
                w_res    = '0;
                w_branch = 1'b1;
                w_brip   = w_target;
            end
            default: w_res = RES_W'(w_b);
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept && w_is_mul_iter) w_state_nxt = ST_BUSY;
                ST_BUSY: if (w_mul_last)                w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // One-entry output register; flush beats load and consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_result     <= '0;
            r_rflags     <= '0;
            r_branch     <= 1'b0;
            r_branch_rip <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load_now) begin
            r_out_valid  <= 1'b1;
            r_result     <= w_res;
            r_rflags     <= w_flags;
            r_branch     <= w_branch;
            r_branch_rip <= w_brip;
        end else if (w_mul_done) begin
            r_out_valid  <= 1'b1;
            r_result     <= w_mul_prod;
            r_rflags     <= w_mul_flags;
            r_branch     <= 1'b0;
            r_branch_rip <= w_mul_rip;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && w_accept && (bus.op > OP_JMP))
            $warning("alu_pipe: unknown op %0d executed as MOV", bus.op);
    end
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (64-bit): flags, branches, backpressure, MUL, flush, reset.
module tb_alu_pipe;
    localparam int unsigned W = 64;
`ifdef ALU_MUL_FAST_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   total = 0;
    int   bad   = 0;
    int   lat;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(W)) bus ();
    alu_pipe #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] c, input logic [63:0] rip);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.oprd1    = a;
        bus.oprd2    = b;
        bus.cond     = c;
        bus.next_rip = rip;
    endtask

    task automatic send(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] c, input logic [63:0] rip);
        issue(o, a, b, c, rip);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [127:0] res, input logic [63:0] fl,
                              input logic br, input logic [63:0] brip);
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk({tag, "_result"}, bus.result, res);
        chk({tag, "_rflags"}, bus.rflags, fl);
        chk({tag, "_branch"}, bus.branch, br);
        chk({tag, "_brip"}, bus.branch_rip, brip);
    endtask

    // Accept a MUL, scramble the operand inputs, and count cycles until out_valid.
    task automatic mul_run(input logic [63:0] a, input logic [63:0] b, output int n);
        send(4'd9, a, b, 4'd0, 64'h4000);
        bus.oprd1 = 64'h1357_9BDF_2468_ACE0;
        bus.oprd2 = 64'h0F0F_0F0F_0F0F_0F0F;
        n = 1;
        while (!bus.out_valid && n < 200) begin
            chk("mul_busy_in_ready", bus.in_ready, 1'b0);
            tick();
            n++;
        end
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.cond      = '0;
        bus.oprd1     = '0;
        bus.oprd2     = '0;
        bus.next_rip  = '0;
        bus.out_ready = 1'b1;

        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, '0);
        chk("rst_rflags", bus.rflags, '0);
        chk("rst_branch", bus.branch, 1'b0);
        chk("rst_brip", bus.branch_rip, '0);
        reset = 1'b0;
        settle();
        chk("post_rst_in_ready", bus.in_ready, 1'b1);

        send(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 4'd0, 64'h100);
        expect_out("add_wrap", 128'h0, 64'h47, 1'b0, 64'h100);

        send(4'd1, 64'h8000_0000_0000_0000, 64'h1, 4'd0, 64'h104);
        expect_out("sub_ovf", 128'h7FFF_FFFF_FFFF_FFFF, 64'h806, 1'b0, 64'h104);

        send(4'd4, 64'hFF, 64'h0F, 4'd0, 64'h108);
        expect_out("xor", 128'hF0, 64'h6, 1'b0, 64'h108);

        send(4'd6, 64'h8000_0000_0000_0001, 64'h41, 4'd0, 64'h10C);
        expect_out("shl1", 128'h2, 64'h3, 1'b0, 64'h10C);

        send(4'd8, 64'h8000_0000_0000_0000, 64'h4, 4'd0, 64'h110);
        expect_out("sar4", 128'hF800_0000_0000_0000, 64'h86, 1'b0, 64'h110);

        send(4'd7, 64'h1234, 64'h40, 4'd0, 64'h114);
        expect_out("shr0", 128'h1234, 64'h86, 1'b0, 64'h114);

        send(4'd7, 64'h3, 64'h1, 4'd0, 64'h118);
        expect_out("shr1", 128'h1, 64'h3, 1'b0, 64'h118);

        send(4'd5, 64'h5555, 64'hDEAD, 4'd0, 64'h2000);
        expect_out("mov", 128'hDEAD, 64'h3, 1'b0, 64'h2000);

        send(4'd1, 64'h5, 64'h5, 4'd0, 64'h11C);
        expect_out("sub_zero", 128'h0, 64'h46, 1'b0, 64'h11C);
        send(4'd10, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 4'd4, 64'h1000);
        expect_out("jcc_e", 128'h0, 64'h46, 1'b1, 64'hFF0);
        send(4'd10, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0, 4'd5, 64'h1000);
        expect_out("jcc_ne", 128'h0, 64'h46, 1'b0, 64'h1000);
        send(4'd11, 64'h0, 64'h10, 4'd0, 64'h1000);
        expect_out("jmp", 128'h0, 64'h46, 1'b1, 64'h1010);

        // Backpressure: hold output three cycles, then consume and accept in one edge.
        send(4'd0, 64'h2, 64'h3, 4'd0, 64'h120);
        bus.out_ready = 1'b0;
        issue(4'd0, 64'h1, 64'h1, 4'd0, 64'h124);
        settle();
        chk("bp_in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("bp_hold", 128'h5, 64'h6, 1'b0, 64'h120);
        end
        bus.out_ready = 1'b1;
        settle();
        chk("bp_release_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        expect_out("bp_next", 128'h2, 64'h2, 1'b0, 64'h124);
        tick();
        chk("bp_drained", bus.out_valid, 1'b0);

        mul_run(64'h1_0000_0000, 64'h1_0000_0000, lat);
        chk("mul_lat", 128'(lat), 128'(MUL_LAT));
        expect_out("mul_2p64", 128'h1_0000_0000_0000_0000, 64'h847, 1'b0, 64'h4000);

        mul_run(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        chk("mul_max_lat", 128'(lat), 128'(MUL_LAT));
        expect_out("mul_max", 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64'h803, 1'b0, 64'h4000);

        send(4'd10, 64'h0, 64'h8, 4'd2, 64'h3000);
        expect_out("jcc_b", 128'h0, 64'h803, 1'b1, 64'h3008);

`ifndef ALU_MUL_FAST_EN
        // Flush in the middle of a MUL, with a competing op presented.
        send(4'd9, 64'h3, 64'h5, 4'd0, 64'h5000);
        for (int i = 0; i < 9; i++) tick();
        chk("mulbusy_in_ready", bus.in_ready, 1'b0);
        issue(4'd0, 64'h9, 64'h9, 4'd0, 64'h5004);
        flush = 1'b1;
        settle();
        chk("flush_in_ready", bus.in_ready, 1'b0);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_rflags", bus.rflags, 64'h803);
        settle();
        chk("flush_in_ready_after", bus.in_ready, 1'b1);
        for (int i = 0; i < 70; i++) tick();
        chk("flush_no_late_mul", bus.out_valid, 1'b0);
`endif

        // Flush wins over consume and accept on a full output register.
        send(4'd0, 64'h1, 64'h1, 4'd0, 64'h6000);
        expect_out("pre_flush", 128'h2, 64'h2, 1'b0, 64'h6000);
        issue(4'd0, 64'h7, 64'h7, 4'd0, 64'h6004);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flushprio_valid", bus.out_valid, 1'b0);
        chk("flushprio_rflags", bus.rflags, 64'h2);
        chk("flushprio_result", bus.result, 128'h2);

        // Reset and flush together in the middle of a MUL.
        send(4'd9, 64'h3, 64'h5, 4'd0, 64'h7000);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        flush = 1'b0;
        settle();
        chk("rstmul_out_valid", bus.out_valid, 1'b0);
        chk("rstmul_in_ready", bus.in_ready, 1'b1);
        chk("rstmul_rflags", bus.rflags, '0);
        chk("rstmul_result", bus.result, '0);
        for (int i = 0; i < 70; i++) tick();
        chk("rstmul_no_late", bus.out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
